// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like port between inst and data masters, data has priority
module sram_req_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic             i_wr,
    input  logic [1:0]       i_size,
    input  logic [3:0]       i_wstrb,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    output logic             i_addr_ok,
    output logic             i_data_ok,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [1:0]       d_size,
    input  logic [3:0]       d_wstrb,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_addr_ok,
    output logic             d_data_ok,
    output logic [31:0]      d_rdata,
    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [3:0]       m_wstrb,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,
    output logic [PTR_W:0]   outstanding
);
    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t             state_q, state_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH-1:0]   tags_q;
    logic               sel_data, sel_req, full, accept, pop, head_tag;

    // Owner selection, request mux and response routing; a locked owner ignores the other master
    always_comb begin
        sel_data  = (state_q == HOLD_D) | ((state_q == IDLE) & d_req);
        sel_req   = sel_data ? d_req : i_req;
        full      = count_q == (PTR_W + 1)'(DEPTH);
        m_req     = sel_req & ~full;
        m_wr      = sel_data ? d_wr    : i_wr;
        m_size    = sel_data ? d_size  : i_size;
        m_wstrb   = sel_data ? d_wstrb : i_wstrb;
        m_addr    = sel_data ? d_addr  : i_addr;
        m_wdata   = sel_data ? d_wdata : i_wdata;
        accept    = m_req & m_addr_ok;
        d_addr_ok = accept & sel_data;
        i_addr_ok = accept & ~sel_data;
        pop       = m_data_ok & (count_q != '0);
        head_tag  = tags_q[rd_ptr_q];
        d_data_ok = pop & head_tag;
        i_data_ok = pop & ~head_tag;
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
        count_d   = count_q + (PTR_W + 1)'(accept) - (PTR_W + 1)'(pop);
        state_d   = (state_q == IDLE)
                  ? (((m_req & ~m_addr_ok) | (sel_req & full)) ? (sel_data ? HOLD_D : HOLD_I) : IDLE)
                  : ((accept | ~sel_req) ? IDLE : state_q);
    end

    // Lock FSM plus owner-tag FIFO; cleared immediately on reset so late responses are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tags_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            if (accept) tags_q[wr_ptr_q] <= sel_data;
            wr_ptr_q <= wr_ptr_q + PTR_W'(accept);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
        end
    end

    assign outstanding = count_q;
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed vectors against a queue-based model of the arbiter
module tb_sram_req_arbiter;
    localparam logic [31:0] IA = 32'h1000_0040, DA = 32'h2000_0080;
    localparam logic [31:0] IWD = 32'h1111_aaaa, DWD = 32'h2222_bbbb;

    logic clk = 1'b0, reset = 1'b1;
    logic i_req = 0, d_req = 0, m_addr_ok = 0, m_data_ok = 0;
    logic [31:0] m_rdata = 32'h0;
    logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic m_req, m_wr;
    logic [1:0] m_size;
    logic [3:0] m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic [1:0] outstanding;

    int checks = 0, errors = 0;

    sram_req_arbiter #(.DEPTH(2), .PTR_W(1)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(1'b0), .i_size(2'd2), .i_wstrb(4'hf), .i_addr(IA), .i_wdata(IWD),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(1'b1), .d_size(2'd1), .d_wstrb(4'h3), .d_addr(DA), .d_wdata(DWD),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, got, exp, $time);
        end
    endtask

    // Model: a master whose presented request was not taken keeps ownership; queue holds owners in order
    int lock = -1;
    bit tagq[$];

    always begin
        int owner;
        logic oreq, ereq, acc, pop;
        @(negedge clk);
        owner = (lock >= 0) ? lock : (d_req ? 1 : 0);
        oreq  = owner ? d_req : i_req;
        ereq  = oreq && (tagq.size() < 2);
        pop   = m_data_ok && (tagq.size() > 0);
        chk("m_req", m_req, ereq);
        chk("m_addr", m_addr, owner ? DA : IA);
        chk("m_wdata", m_wdata, owner ? DWD : IWD);
        chk("m_ctl", {m_wr, m_size, m_wstrb}, owner ? {1'b1, 2'd1, 4'h3} : {1'b0, 2'd2, 4'hf});
        chk("i_addr_ok", i_addr_ok, ereq && m_addr_ok && owner == 0);
        chk("d_addr_ok", d_addr_ok, ereq && m_addr_ok && owner == 1);
        chk("i_data_ok", i_data_ok, pop && !tagq[0]);
        chk("d_data_ok", d_data_ok, pop && tagq[0]);
        chk("rdata", {i_rdata, d_rdata}, {m_rdata, m_rdata});
        chk("outstanding", outstanding, tagq.size());
        @(posedge clk);
        if (reset) begin
            lock = -1;
            tagq.delete();
        end else begin
            owner = (lock >= 0) ? lock : (d_req ? 1 : 0);
            oreq  = owner ? d_req : i_req;
            acc   = oreq && (tagq.size() < 2) && m_addr_ok;
            if (m_data_ok && tagq.size() > 0) void'(tagq.pop_front());
            if (acc) tagq.push_back(owner[0]);
            lock = (oreq && !acc) ? owner : -1;
        end
    end

    task automatic cyc(input logic ir, input logic dr, input logic aok, input logic dok);
        @(posedge clk);
        #1;
        i_req = ir; d_req = dr; m_addr_ok = aok; m_data_ok = dok;
        m_rdata = $urandom;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #12 reset = 1'b0;
        // both request, data wins
        cyc(1, 1, 1, 0);
        chk("t1 m_addr", m_addr, DA);
        chk("t1 d_addr_ok", d_addr_ok, 1);
        chk("t1 i_addr_ok", i_addr_ok, 0);
        cyc(0, 0, 0, 0);
        chk("t1 count", outstanding, 1);
        cyc(0, 0, 0, 1);
        chk("t1 d_data_ok", d_data_ok, 1);
        // inst locked while d_req arrives
        cyc(1, 0, 0, 0);
        chk("t2 m_addr c1", m_addr, IA);
        cyc(1, 1, 0, 0);
        chk("t2 m_addr c2", m_addr, IA);
        chk("t2 d_addr_ok c2", d_addr_ok, 0);
        cyc(1, 1, 0, 0);
        chk("t2 m_addr c3", m_addr, IA);
        cyc(1, 1, 1, 0);
        chk("t2 i_addr_ok c4", i_addr_ok, 1);
        cyc(0, 1, 1, 0);
        chk("t2 d_addr_ok c5", d_addr_ok, 1);
        cyc(0, 0, 0, 1);
        chk("t2 i_data_ok", i_data_ok, 1);
        cyc(0, 0, 0, 1);
        chk("t2 d_data_ok", d_data_ok, 1);
        // fill to DEPTH and drain in order
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 1, 0);
        chk("t3 count full", outstanding, 2);
        chk("t3 m_req full", m_req, 0);
        cyc(1, 0, 1, 1);
        chk("t3 i_data_ok first", i_data_ok, 1);
        chk("t3 m_req still full", m_req, 0);
        cyc(1, 0, 1, 1);
        chk("t3 d_data_ok second", d_data_ok, 1);
        chk("t3 i_addr_ok", i_addr_ok, 1);
        // push and pop together keep count at 1 while pointers wrap
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 1, 1);
            chk("t4 i_data_ok", i_data_ok, 1);
            chk("t4 count a", outstanding, 1);
            cyc(1, 0, 1, 1);
            chk("t4 d_data_ok", d_data_ok, 1);
            chk("t4 count b", outstanding, 1);
        end
        cyc(0, 0, 0, 1);
        chk("t4 drain i_data_ok", i_data_ok, 1);
        // spurious response
        cyc(0, 0, 0, 1);
        chk("t5 data_ok", {i_data_ok, d_data_ok}, 0);
        chk("t5 count", outstanding, 0);
        // async reset in HOLD_D with count 2
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        chk("t6 m_req full", m_req, 0);
        cyc(1, 1, 0, 0);
        chk("t6 m_addr hold", m_addr, DA);
        chk("t6 count", outstanding, 2);
        #1 reset = 1'b1;
        #1;
        chk("t6 async count", outstanding, 0);
        chk("t6 m_req after", m_req, 1);
        chk("t6 m_addr after", m_addr, DA);
        d_req = 0;
        #1;
        chk("t6 m_addr follows", m_addr, IA);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 1);
        chk("t6 late resp dropped", {i_data_ok, d_data_ok}, 0);
        cyc(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
